exe_muldiv_ctrl: RTL and testbench

- Sequences the multi-cycle HI/LO operations of the execute stage: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Owns the HI/LO architectural registers and an iterative divider core.
- Raises a pipeline stall while an operation is in flight, so the EX-stage instruction and operands stay frozen until HI/LO are written.
- Sits beside the EX-stage ALU; its result is muxed into the EX result for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/exe_muldiv_ctrl_if.sv | 18 +
 rtl/exe_muldiv_ctrl_div_iter.sv | 39 +++
 rtl/exe_muldiv_ctrl.sv | 160 ++++++++++++++++
 tb/tb_exe_muldiv_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM states, iteration count.
package muldiv_pkg;

   localparam logic [2:0] MD_OP_MULT  = 3'd0;
   localparam logic [2:0] MD_OP_MULTU = 3'd1;
   localparam logic [2:0] MD_OP_DIV   = 3'd2;
   localparam logic [2:0] MD_OP_DIVU  = 3'd3;
   localparam logic [2:0] MD_OP_MFHI  = 3'd4;
   localparam logic [2:0] MD_OP_MFLO  = 3'd5;
   localparam logic [2:0] MD_OP_MTHI  = 3'd6;
   localparam logic [2:0] MD_OP_MTLO  = 3'd7;

   localparam int MD_ITERS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   // Magnitude of a possibly-signed operand; 0x80000000 comes out as unsigned 2^31.
   function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/exe_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO unit signal bundle; master is the pipeline, slave is exe_muldiv_ctrl.
interface exe_muldiv_ctrl_if #(parameter int WIDTH = 32);
   logic             op_valid;
   logic [2:0]       op;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             flush;
   logic             stall_req;
   logic [WIDTH-1:0] result;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output op_valid, op, srca, srcb, flush,
                   input  stall_req, result, busy, hi, lo);
   modport slave  (input  op_valid, op, srca, srcb, flush,
                   output stall_req, result, busy, hi, lo);
endinterface

// File: rtl/exe_muldiv_ctrl_div_iter.sv
// Restoring unsigned divider, one quotient bit per step. Outputs show the result of the
// step being applied this cycle so the caller can commit on the final step's edge.
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
   logic [WIDTH:0]   shifted, diff;
   logic             ge;

   assign shifted   = {rem_q, quo_q[WIDTH-1]};
   assign diff      = shifted - {1'b0, dsr_q};
   assign ge        = ~diff[WIDTH];
   assign quotient  = {quo_q[WIDTH-2:0], ge};
   assign remainder = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         quo_q <= '0;
         rem_q <= '0;
         dsr_q <= '0;
      end else if (load) begin
         quo_q <= dividend;
         rem_q <= '0;
         dsr_q <= divisor;
      end else if (step) begin
         quo_q <= quotient;
         rem_q <= remainder;
      end
   end
endmodule

// File: rtl/exe_muldiv_ctrl.sv
// EX-stage HI/LO sequencer: MULT/DIV take 33 stall cycles (MUL 2 with MULDIV_FAST_MUL_EN),
// then one DONE cycle; MTxx/MFxx complete without stalling; flush aborts without writing HI/LO.
module exe_muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int          WIDTH    = 32,
   parameter logic [31:0] HILO_RST = 32'h0
) (
   input  logic               clk,
   input  logic               resetn,
   exe_muldiv_ctrl_if.slave   md
);
   localparam int CNT_W = $clog2(MD_ITERS);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

   logic               is_sgn, div_load, div_step, stall;
   logic [WIDTH-1:0]   abs_a, abs_b, q_mag, r_mag, quo, rem, result;
   logic [2*WIDTH-1:0] prod_mag, prod;

   assign is_sgn = ~md.op[0];
   assign abs_a  = md_mag(md.srca, is_sgn);
   assign abs_b  = md_mag(md.srcb, is_sgn);

`ifdef MULDIV_FAST_MUL_EN
   assign prod_mag = {{WIDTH{1'b0}}, mcand_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
   // Shift-add: multiplier sits in the low half and drains out as the product shifts in.
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_step;
   assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign acc_step = {sum, acc_q[WIDTH-1:1]};
   assign prod_mag = acc_step;
`endif
   assign prod = qneg_q ? -prod_mag : prod_mag;

   div_iter #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .load      (div_load),
      .step      (div_step),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (q_mag),
      .remainder (r_mag)
   );

   assign quo = qneg_q ? -q_mag : q_mag;
   assign rem = rneg_q ? -r_mag : r_mag;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      div_load = 1'b0;
      div_step = 1'b0;
      stall    = 1'b0;
      result   = '0;
      case (state_q)
         ST_IDLE: begin
            if (md.op_valid && !md.flush) begin
               if (!md.op[2]) begin
                  stall    = 1'b1;
                  mcand_d  = abs_a;
                  acc_d    = {{WIDTH{1'b0}}, abs_b};
                  qneg_d   = is_sgn & (md.srca[WIDTH-1] ^ md.srcb[WIDTH-1]);
                  rneg_d   = is_sgn & md.srca[WIDTH-1];
                  dz_d     = (md.srcb == '0);
                  cnt_d    = '0;
                  div_load = md.op[1];
                  state_d  = md.op[1] ? ST_DIV : ST_MUL;
               end else begin
                  case (md.op)
                     MD_OP_MTHI: hi_d   = md.srca;
                     MD_OP_MTLO: lo_d   = md.srca;
                     MD_OP_MFHI: result = hi_q;
                     MD_OP_MFLO: result = lo_q;
                     default: ;
                  endcase
               end
            end
         end
         ST_MUL: begin
            if (md.flush) begin
               state_d = ST_IDLE;
            end else begin
               stall = 1'b1;
`ifdef MULDIV_FAST_MUL_EN
               {hi_d, lo_d} = prod;
               state_d      = ST_DONE;
`else
               acc_d = acc_step;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MD_ITERS - 1)) begin
                  {hi_d, lo_d} = prod;
                  state_d      = ST_DONE;
               end
`endif
            end
         end
         ST_DIV: begin
            if (md.flush) begin
               state_d = ST_IDLE;
            end else begin
               stall    = 1'b1;
               div_step = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MD_ITERS - 1)) begin
                  hi_d    = dz_q ? md.srca : rem;
                  lo_d    = dz_q ? '1 : quo;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= HILO_RST;
         lo_q    <= HILO_RST;
         mcand_q <= '0;
         acc_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   assign md.stall_req = resetn & stall;
   assign md.result    = result;
   assign md.busy      = (state_q != ST_IDLE);
   assign md.hi        = hi_q;
   assign md.lo        = lo_q;
endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Scoreboard bench for exe_muldiv_ctrl: completions are checked at the DONE cycle by a monitor.
module tb_exe_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam logic [31:0] TB_RST = 32'h0BAD_F00D;
   localparam int LIM = 100;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_ST = 2;
`else
   localparam int MUL_ST = 33;
`endif

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          stall;
   } exp_t;

   logic clk = 1'b0;
   logic resetn;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   exe_muldiv_ctrl_if #(.WIDTH(32)) mif ();

   exe_muldiv_ctrl #(.WIDTH(32), .HILO_RST(TB_RST)) dut (
      .clk    (clk),
      .resetn (resetn),
      .md     (mif)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Monitor: count stall cycles; a DONE cycle (busy, no stall, no abort) retires one expectation.
   initial begin
      int   stall_cnt;
      exp_t e;
      stall_cnt = 0;
      forever begin
         @(negedge clk);
         if (mif.stall_req) begin
            stall_cnt++;
         end else begin
            if (mif.busy && !mif.flush && resetn) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got completion expected none");
               end else begin
                  e = exp_q.pop_front();
                  chk({e.name, ".hi"}, mif.hi, e.hi);
                  chk({e.name, ".lo"}, mif.lo, e.lo);
                  chk({e.name, ".stall"}, 32'(stall_cnt), 32'(e.stall));
               end
            end
            stall_cnt = 0;
         end
      end
   end

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, b,
                         input logic [31:0] ehi, elo, input int est);
      exp_t e;
      int   n;
      e.name = name; e.hi = ehi; e.lo = elo; e.stall = est;
      exp_q.push_back(e);
      mif.op_valid = 1'b1; mif.op = op; mif.srca = a; mif.srcb = b;
      @(posedge clk); #1;
      n = 0;
      while (mif.busy && n < LIM) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, ".timeout"}, 32'(n >= LIM), 32'd0);
      mif.op_valid = 1'b0;
   endtask

   task automatic mt(input logic [2:0] op, input logic [31:0] a);
      mif.op_valid = 1'b1; mif.op = op; mif.srca = a;
      @(posedge clk); #1;
      mif.op_valid = 1'b0;
   endtask

   task automatic mf(input string name, input logic [2:0] op, input logic [31:0] exp);
      mif.op_valid = 1'b1; mif.op = op;
      #2;
      chk({name, ".result"}, mif.result, exp);
      chk({name, ".nostall"}, 32'(mif.stall_req), 32'd0);
      @(posedge clk); #1;
      mif.op_valid = 1'b0;
   endtask

   task automatic start_div_to_t10();
      mif.op_valid = 1'b1; mif.op = MD_OP_DIV; mif.srca = 32'd100; mif.srcb = 32'd7;
      repeat (10) @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0;
      mif.op_valid = 1'b0; mif.op = 3'd0; mif.srca = '0; mif.srcb = '0; mif.flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.hi", mif.hi, TB_RST);
      chk("rst.lo", mif.lo, TB_RST);
      chk("rst.busy", 32'(mif.busy), 32'd0);
      chk("rst.stall", 32'(mif.stall_req), 32'd0);
      chk("rst.result", mif.result, 32'd0);
      resetn = 1'b1;

      run_op("divu_100_7", MD_OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
      mf("mflo_after_divu", MD_OP_MFLO, 32'd14);
      mf("mfhi_after_divu", MD_OP_MFHI, 32'd2);
      run_op("div_m7_2", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      run_op("mult_min_min", MD_OP_MULT, 32'h8000_0000, 32'h8000_0000,
             32'h4000_0000, 32'h0000_0000, MUL_ST);
      run_op("multu_ff_ff", MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001, MUL_ST);
      run_op("mult_m3_5", MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_ST);
      run_op("divu_5_0", MD_OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
      run_op("div_m16_0", MD_OP_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 33);
      run_op("div_min_m1", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

      mt(MD_OP_MTHI, 32'hA5A5_A5A5);
      mf("mthi_mfhi", MD_OP_MFHI, 32'hA5A5_A5A5);

      mif.op_valid = 1'b1; mif.op = MD_OP_MTLO; mif.srca = 32'hDEAD_BEEF; mif.flush = 1'b1;
      @(posedge clk); #1;
      mif.op_valid = 1'b0; mif.flush = 1'b0;
      chk("mtlo_flushed.lo", mif.lo, 32'h8000_0000);

      mt(MD_OP_MTHI, 32'h0000_1234);
      mt(MD_OP_MTLO, 32'h0000_5678);
      start_div_to_t10();
      chk("flush_t10.pre_stall", 32'(mif.stall_req), 32'd1);
      mif.flush = 1'b1;
      #1;
      chk("flush_t10.stall", 32'(mif.stall_req), 32'd0);
      @(posedge clk); #1;
      mif.flush = 1'b0; mif.op_valid = 1'b0;
      chk("flush_t10.busy", 32'(mif.busy), 32'd0);
      chk("flush_t10.hi", mif.hi, 32'h0000_1234);
      chk("flush_t10.lo", mif.lo, 32'h0000_5678);

      start_div_to_t10();
      resetn = 1'b0;
      @(posedge clk); #1;
      mif.op_valid = 1'b0;
      chk("reset_t10.hi", mif.hi, TB_RST);
      chk("reset_t10.lo", mif.lo, TB_RST);
      chk("reset_t10.busy", 32'(mif.busy), 32'd0);
      resetn = 1'b1;
      #1;
      chk("reset_t10.stall", 32'(mif.stall_req), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
